// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit count, glyph table, flag bit positions.
// Segments are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int NUM_FLAGS  = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

  typedef logic [1:0] digit_idx_t;

  // Entry n is the glyph for hex digit n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input digit_idx_t d);
    return ~(NUM_DIGITS'(1) << d);
  endfunction

endpackage

// File: rtl/alu_result_display_hex_to_seg7.sv
// Purpose: combinational hex nibble to active-low 7-segment glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/alu_result_display.sv
// Purpose: capture ALU result/flags, scan them as 4 hex digits; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: capture 1 cycle, scanned digit shows new nibble 1 cycle later, all digits within 4*DIV+1 cycles.
// Backpressure: in_ready = ~hold (and low in reset); refused results are simply not captured.
module alu_result_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_zero,
  input  logic        in_carry,
  input  logic        in_overflow,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [2:0]  flag_leds
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("alu_result_display: CLK_HZ/SCAN_HZ must be at least 2");
    end
  endgenerate

  logic [15:0]          value_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] flags_in;
  logic [CNT_W-1:0]     scan_cnt;
  digit_idx_t           digit_idx;
  logic                 xfer;
  logic [3:0]           nibble;
  logic [6:0]           glyph;
  logic                 blank;

  // ---------------- capture ----------------
  assign in_ready = reset & ~hold;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_ZERO]  = in_zero;
    flags_in[FLAG_CARRY] = in_carry;
    flags_in[FLAG_OVF]   = in_overflow;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
      flags_q <= '0;
    end else if (xfer) begin
      value_q <= in_data;
      flags_q <= flags_in;
    end
  end

  assign flag_leds = flags_q;

  // ---------------- scan ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  assign nibble = value_q[{digit_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // A digit is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (value_q[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
      lead_zero[i] = lead_zero[i+1] & (value_q[4*i +: 4] == 4'd0);
    end
  end

  assign blank = lead_zero[digit_idx];
`else
  assign blank = 1'b0;
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= blank ? SEG_BLANK : glyph;
      an  <= anode_sel_n(digit_idx);
      dp  <= ~((digit_idx == 2'd0) & flags_q[FLAG_CARRY]);
    end
  end

endmodule
